mode_sequencer: RTL

- Parametrised display-mode controller for the watch top level. Replaces direct DIP-switch mode decode with debounced push-button mode cycling, a home button, a lock from active set modes, and an inactivity auto-return to the home screen.
- Selects the active mode's LCD character byte from a packed per-mode bus and drives the lcd_driver data_char input.
- Pulses mode_chg on every mode switch so the display path can redraw.

---
 rtl/mode_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mode_sequencer.sv
// mode_sequencer: debounced push-button display-mode controller.
// Cycles modes, returns home on button or inactivity, selects LCD char.
//
// Ports:
//   clk, rst       system clock, async active-high reset
//   en_tick        debounce sample strobe (1 clk wide)
//   en_1hz         one-second strobe (1 clk wide)
//   sw_mode        raw mode-advance button
//   sw_home        raw home button
//   lock           high while a set mode edits; freezes mode
//   mode_data_in   packed per-mode char bytes, mode k at [8k+7:8k]
//   mode           current mode index
//   mode_onehot    one-hot decode of mode
//   data_char      registered char byte of current mode
//   mode_chg       one-clk pulse when mode changes
module mode_sequencer #(
    parameter int N_MODES   = 4,
    parameter int MODE_W    = 2,
    parameter int DEB_CNT   = 20,
    parameter int TIMEOUT_S = 30,
    parameter int HOME_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_tick,
    input  logic                 en_1hz,
    input  logic                 sw_mode,
    input  logic                 sw_home,
    input  logic                 lock,
    input  logic [N_MODES*8-1:0] mode_data_in,
    output logic [MODE_W-1:0]    mode,
    output logic [N_MODES-1:0]   mode_onehot,
    output logic [7:0]           data_char,
    output logic                 mode_chg
);

    localparam logic [MODE_W-1:0] HOME = MODE_W'(HOME_MODE);
    localparam logic [MODE_W-1:0] LAST = MODE_W'(N_MODES - 1);
    localparam logic [7:0]        DEB  = 8'(DEB_CNT);
    localparam logic [7:0]        TMO  = 8'(TIMEOUT_S);
    localparam logic [7:0]        BLANK = 8'h20;

    // Bit 0 = mode button, bit 1 = home button.
    logic [1:0] raw;
    logic [1:0] sync1, sync2;
    logic [1:0] stable, stable_q;
    logic [1:0] armed;
    logic [1:0] prime;
    logic [7:0] deb_cnt [2];
    logic [1:0] press;

    logic [7:0]        idle_cnt;
    logic              timeout;
    logic [MODE_W-1:0] mode_nxt;
    logic [7:0]        sel_char;

    assign raw = {sw_home, sw_mode};

    // A button only becomes armed once it has been seen released after
    // reset (prime waits out the synchroniser fill), so a button held
    // through reset never produces a press.
    assign press = stable & ~stable_q & armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= '0;
            sync2      <= '0;
            stable     <= '0;
            stable_q   <= '0;
            armed      <= '0;
            prime      <= '0;
            deb_cnt[0] <= '0;
            deb_cnt[1] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            prime    <= {prime[0], 1'b1};
            armed    <= armed | (~sync2 & {2{prime[1]}});
            for (int i = 0; i < 2; i++) begin
                if (en_tick) begin
                    if (sync2[i] == stable[i]) begin
                        deb_cnt[i] <= '0;
                    end else if (deb_cnt[i] + 8'd1 == DEB) begin
                        stable[i]  <= sync2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end
            end
        end
    end

    assign timeout = (TIMEOUT_S != 0) && (idle_cnt == TMO);

    always_comb begin
        mode_nxt = mode;
        if (lock) begin
            mode_nxt = mode;
        end else if (press[1]) begin
            mode_nxt = HOME;
        end else if (press[0]) begin
            mode_nxt = (mode == LAST) ? '0 : mode + 1'b1;
        end else if (timeout) begin
            mode_nxt = HOME;
        end
    end

    always_comb begin
        sel_char = BLANK;
        for (int i = 0; i < N_MODES; i++) begin
            if (mode == MODE_W'(i)) begin
                sel_char = mode_data_in[8*i +: 8];
            end
        end
    end

    always_comb begin
        mode_onehot = '0;
        for (int i = 0; i < N_MODES; i++) begin
            mode_onehot[i] = (mode == MODE_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode      <= HOME;
            mode_chg  <= 1'b0;
            data_char <= BLANK;
            idle_cnt  <= '0;
        end else begin
            mode      <= mode_nxt;
            mode_chg  <= (mode_nxt != mode);
            data_char <= sel_char;
            if ((|press) || lock || (mode == HOME) || timeout) begin
                idle_cnt <= '0;
            end else if (en_1hz && (idle_cnt < TMO)) begin
                idle_cnt <= idle_cnt + 8'd1;
            end
        end
    end

endmodule
